// File: rtl/acc_group_if.sv
// Stream bundle between the MUL stage, this accumulator and its downstream consumer.
// The master side drives products in and accepts sums out; the slave side is the accumulator.
interface acc_group_if #(
  parameter int GROUP_SIZE = 8,
  parameter int IN_WIDTH   = 16,
  parameter int ACC_WIDTH  = 32
);
  logic [GROUP_SIZE*IN_WIDTH-1:0]  data_in;
  logic                            valid_in;
  logic                            avail_out;
  logic [GROUP_SIZE*ACC_WIDTH-1:0] data_out;
  logic                            valid_out;
  logic                            avail_in;

  modport master (
    output data_in, valid_in, avail_in,
    input  avail_out, data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, avail_in,
    output avail_out, data_out, valid_out
  );
endinterface

// File: rtl/acc_group.sv
// Lane-wise product accumulator: sums num_reads_per_iter products per lane, emits one group per
// iteration for num_iters iterations. Products are buffered in a 4-entry FIFO ahead of the FSM.
module acc_group #(
  parameter int GROUP_SIZE             = 8,
  parameter int IN_WIDTH               = 16,
  parameter int ACC_WIDTH              = 32,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  acc_group_if.slave                        bus,
  output logic                              done,
  output logic                              overflow_err
);
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                              state;
  logic [GROUP_SIZE*IN_WIDTH-1:0]      mem [DEPTH];
  logic [1:0]                          wr_ptr;
  logic [1:0]                          rd_ptr;
  logic [2:0]                          count;
  logic [LOG_MAX_ITERS-1:0]            iters_r;
  logic [LOG_MAX_READS_PER_ITER-1:0]   reads_r;
  logic [LOG_MAX_READS_PER_ITER-1:0]   reads_copy_r;
  logic [ACC_WIDTH-1:0]                acc   [GROUP_SIZE];
  logic [ACC_WIDTH-1:0]                out_r [GROUP_SIZE];
  logic [ACC_WIDTH-1:0]                sum   [GROUP_SIZE];
  logic [GROUP_SIZE*IN_WIDTH-1:0]      head;
  logic [GROUP_SIZE*ACC_WIDTH-1:0]     out_flat;
  logic                                full, empty, push, pop, fire, cfg_ok;

  function automatic logic [ACC_WIDTH-1:0] wrap_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [IN_WIDTH-1:0]  b);
    return a + ACC_WIDTH'(b);
  endfunction

  assign full   = (count == 3'(DEPTH));
  assign empty  = (count == 3'd0);
  assign push   = bus.valid_in & ~full;
  // A configure cycle neither pops nor emits: the group in flight is being abandoned.
  assign pop    = (state == ACCUM) & ~empty & ~configure;
  assign fire   = (state == OUT) & bus.avail_in & ~configure;
  assign cfg_ok = (num_iters != '0) & (num_reads_per_iter != '0);
  assign head   = mem[rd_ptr];

  assign bus.avail_out = (count <= 3'd2);
  assign bus.valid_out = fire;
  assign bus.data_out  = out_flat;

  always_comb begin
    for (int i = 0; i < GROUP_SIZE; i++) begin
      sum[i] = wrap_add(acc[i], head[i*IN_WIDTH +: IN_WIDTH]);
      out_flat[i*ACC_WIDTH +: ACC_WIDTH] = out_r[i];
    end
  end

  // ---- FIFO storage ----
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // ---- FIFO pointers, occupancy, sticky overflow ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
      if (bus.valid_in && full) overflow_err <= 1'b1;
    end
  end

  // ---- Accumulate / emit FSM ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      iters_r      <= '0;
      reads_r      <= '0;
      reads_copy_r <= '0;
      done         <= 1'b0;
      for (int i = 0; i < GROUP_SIZE; i++) begin
        acc[i]   <= '0;
        out_r[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (configure) begin
        for (int i = 0; i < GROUP_SIZE; i++) acc[i] <= '0;
        if (cfg_ok) begin
          iters_r      <= num_iters;
          reads_r      <= num_reads_per_iter;
          reads_copy_r <= num_reads_per_iter;
          state        <= ACCUM;
        end else begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          ACCUM: begin
            if (pop) begin
              for (int i = 0; i < GROUP_SIZE; i++) acc[i] <= sum[i];
              reads_r <= reads_r - LOG_MAX_READS_PER_ITER'(1);
              if (reads_r == LOG_MAX_READS_PER_ITER'(1)) begin
                for (int i = 0; i < GROUP_SIZE; i++) out_r[i] <= sum[i];
                state <= OUT;
              end
            end
          end
          OUT: begin
            if (fire) begin
              for (int i = 0; i < GROUP_SIZE; i++) acc[i] <= '0;
              reads_r <= reads_copy_r;
              if (iters_r == LOG_MAX_ITERS'(1)) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                iters_r <= iters_r - LOG_MAX_ITERS'(1);
                state   <= ACCUM;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_acc_group.sv
// Randomised and directed bench for acc_group; expected sums come from a lane-wise reference model
// that chops the pushed products into groups of num_reads_per_iter and adds them arithmetically.
module tb_acc_group;
  localparam int G    = 8;
  localparam int IW   = 16;
  localparam int AW   = 32;
  localparam int AW16 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        configure, configure_b;
  logic [15:0] num_iters, num_reads, num_iters_b, num_reads_b;
  logic        done, overflow_err, done_b, overflow_b;

  acc_group_if #(.GROUP_SIZE(G), .IN_WIDTH(IW), .ACC_WIDTH(AW))   bus ();
  acc_group_if #(.GROUP_SIZE(G), .IN_WIDTH(IW), .ACC_WIDTH(AW16)) bus_b ();

  acc_group #(.GROUP_SIZE(G), .IN_WIDTH(IW), .ACC_WIDTH(AW),
              .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads), .bus(bus), .done(done), .overflow_err(overflow_err));

  acc_group #(.GROUP_SIZE(G), .IN_WIDTH(IW), .ACC_WIDTH(AW16),
              .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)) dut16 (
    .clk(clk), .rst(rst), .configure(configure_b), .num_iters(num_iters_b),
    .num_reads_per_iter(num_reads_b), .bus(bus_b), .done(done_b), .overflow_err(overflow_b));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt, done_cyc, vout_cyc, done_b_cnt;
  bit stop_rand;

  logic [G*IW-1:0]   push_q [$];
  logic [G*AW-1:0]   out_q  [$];
  logic [G*AW-1:0]   exp_q  [$];
  logic [G*AW16-1:0] out_b_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.valid_out === 1'b1) begin out_q.push_back(bus.data_out); vout_cyc = cyc; end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (bus_b.valid_out === 1'b1) out_b_q.push_back(bus_b.data_out);
      if (done_b === 1'b1) done_b_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_books();
    out_q.delete(); push_q.delete(); exp_q.delete(); out_b_q.delete();
    done_cnt = 0; done_b_cnt = 0; done_cyc = -1; vout_cyc = -1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    configure = 0; num_iters = 0; num_reads = 0;
    configure_b = 0; num_iters_b = 0; num_reads_b = 0;
    bus.valid_in = 0; bus.data_in = '0; bus.avail_in = 1;
    bus_b.valid_in = 0; bus_b.data_in = '0; bus_b.avail_in = 1;
    #2 rst = 1'b0;
    tick(2);
    clear_books();
    rst = 1'b1;
    tick(1);
  endtask

  task automatic do_config(input int it, input int rd);
    configure = 1; num_iters = 16'(it); num_reads = 16'(rd);
    tick();
    configure = 0;
  endtask

  function automatic logic [G*IW-1:0] rand_word();
    logic [G*IW-1:0] w;
    for (int i = 0; i < G; i++) w[i*IW +: IW] = IW'($urandom);
    return w;
  endfunction

  // Waits for room, then presents one product group for a single cycle.
  task automatic push_word(input logic [G*IW-1:0] w, input int gap);
    int t = 0;
    while (bus.avail_out !== 1'b1 && t < 300) begin tick(); t++; end
    if (bus.avail_out !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL push_wait: avail_out=%b required 1 within 300 cycles", bus.avail_out);
    end
    bus.valid_in = 1; bus.data_in = w;
    tick();
    bus.valid_in = 0;
    if (gap > 0) tick(gap);
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int t = 0;
    while (out_q.size() < n && t < budget) begin tick(); t++; end
  endtask

  // Reference: group g, lane i = sum of lane i over pushes g*rd .. g*rd+rd-1, modulo 2^AW.
  task automatic build_expected(input int it, input int rd);
    exp_q.delete();
    for (int g = 0; g < it; g++) begin
      logic [G*AW-1:0] e;
      e = '0;
      for (int i = 0; i < G; i++) begin
        longint unsigned s;
        s = 0;
        for (int r = 0; r < rd; r++) begin
          logic [G*IW-1:0] w;
          w = push_q[g*rd + r];
          s += longint'(w[i*IW +: IW]);
        end
        e[i*AW +: AW] = s[AW-1:0];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    configure = 0; num_iters = 0; num_reads = 0;
    configure_b = 0; num_iters_b = 0; num_reads_b = 0;
    bus.valid_in = 0; bus.data_in = '0; bus.avail_in = 1;
    bus_b.valid_in = 0; bus_b.data_in = '0; bus_b.avail_in = 1;
    #2 rst = 1'b0;
    #1;
    vectors++; if (bus.avail_out !== 1'b1) begin miscompares++; $display("FAIL rst_avail_out: got %b want 1", bus.avail_out); end
    vectors++; if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_valid_out: got %b want 0", bus.valid_out); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
    vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b want 0", overflow_err); end
    vectors++; if (bus.data_out !== '0) begin miscompares++; $display("FAIL rst_data_out: got %h want 0", bus.data_out); end
    tick(2);
    clear_books();
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    logic [G*AW-1:0] want;
    apply_reset();
    for (int i = 0; i < G; i++) want[i*AW +: AW] = AW'(12);
    do_config(1, 4);
    for (int k = 0; k < 4; k++) push_word({G{16'd3}}, 0);
    wait_outputs(1, 50);
    tick(3);
    vectors++; if (out_q.size() != 1) begin miscompares++; $display("FAIL basic_count: got %0d outputs want 1", out_q.size()); end
    vectors++; if (out_q.size() > 0 && out_q[0] !== want) begin miscompares++; $display("FAIL basic_sum: got %h want %h", out_q[0], want); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    vectors++; if (done_cyc != vout_cyc + 1) begin miscompares++; $display("FAIL basic_done_timing: done at %0d want %0d", done_cyc, vout_cyc + 1); end
  endtask

  task automatic test_multi_iter();
    apply_reset();
    do_config(3, 2);
    for (int k = 0; k < 6; k++) begin
      logic [G*IW-1:0] w;
      for (int i = 0; i < G; i++) w[i*IW +: IW] = IW'(i + k);
      push_word(w, k % 2);
    end
    wait_outputs(3, 100);
    tick(3);
    vectors++; if (out_q.size() != 3) begin miscompares++; $display("FAIL multi_count: got %0d want 3", out_q.size()); end
    for (int j = 0; j < 3 && j < out_q.size(); j++) begin
      logic [G*AW-1:0] want;
      for (int i = 0; i < G; i++) want[i*AW +: AW] = AW'(2*i + 1 + 4*j);
      vectors++; if (out_q[j] !== want) begin miscompares++; $display("FAIL multi_group%0d: got %h want %h", j, out_q[j], want); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL multi_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int k = 0; k < 6; k++) push_q.push_back(rand_word());
    build_expected(3, 2);
    bus.avail_in = 0;
    do_config(3, 2);
    fork
      begin
        for (int k = 0; k < 6; k++) push_word(push_q[k], 0);
      end
    join_none
    tick(5);
    for (int c = 0; c < 5; c++) begin
      vectors++; if (bus.data_out !== exp_q[0]) begin miscompares++; $display("FAIL stall_hold c%0d: got %h want %h", c, bus.data_out, exp_q[0]); end
      vectors++; if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL stall_valid c%0d: got %b want 0", c, bus.valid_out); end
      tick();
    end
    vectors++; if (bus.avail_out !== 1'b0) begin miscompares++; $display("FAIL stall_avail_out: got %b want 0", bus.avail_out); end
    bus.avail_in = 1;
    tick(2);
    vectors++; if (out_q.size() != 1) begin miscompares++; $display("FAIL stall_release: got %0d outputs want 1", out_q.size()); end
    wait_outputs(3, 200);
    wait fork;
    tick(3);
    vectors++; if (out_q.size() != 3) begin miscompares++; $display("FAIL stall_count: got %0d want 3", out_q.size()); end
    for (int j = 0; j < 3 && j < out_q.size(); j++) begin
      vectors++; if (out_q[j] !== exp_q[j]) begin miscompares++; $display("FAIL stall_group%0d: got %h want %h", j, out_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_wrap();
    int t = 0;
    apply_reset();
    configure_b = 1; num_iters_b = 16'd1; num_reads_b = 16'd2;
    tick();
    configure_b = 0;
    bus_b.valid_in = 1; bus_b.data_in = {G{16'hFFFF}};
    tick();
    bus_b.data_in = {G{16'h0002}};
    tick();
    bus_b.valid_in = 0;
    while (out_b_q.size() < 1 && t < 50) begin tick(); t++; end
    tick(2);
    vectors++; if (out_b_q.size() != 1) begin miscompares++; $display("FAIL wrap_count: got %0d want 1", out_b_q.size()); end
    vectors++; if (out_b_q.size() > 0 && out_b_q[0] !== {G{16'h0001}}) begin miscompares++; $display("FAIL wrap_sum: got %h want %h", out_b_q[0], {G{16'h0001}}); end
    vectors++; if (done_b_cnt != 1) begin miscompares++; $display("FAIL wrap_done: got %0d want 1", done_b_cnt); end
  endtask

  task automatic test_overflow();
    logic [G*IW-1:0] w [5];
    apply_reset();
    for (int k = 0; k < 5; k++) w[k] = rand_word();
    // Fill the FIFO while idle, then force a fifth push into the full FIFO.
    for (int k = 0; k < 4; k++) begin
      bus.valid_in = 1; bus.data_in = w[k];
      tick();
    end
    vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b want 0", overflow_err); end
    vectors++; if (bus.avail_out !== 1'b0) begin miscompares++; $display("FAIL ovf_avail: got %b want 0", bus.avail_out); end
    bus.data_in = w[4];
    tick();
    bus.valid_in = 0;
    vectors++; if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", overflow_err); end
    for (int k = 0; k < 4; k++) push_q.push_back(w[k]);
    build_expected(1, 4);
    do_config(1, 4);
    wait_outputs(1, 50);
    tick(4);
    vectors++; if (out_q.size() != 1) begin miscompares++; $display("FAIL ovf_count: got %0d want 1", out_q.size()); end
    vectors++; if (out_q.size() > 0 && out_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL ovf_sum: got %h want %h", out_q[0], exp_q[0]); end
    vectors++; if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
  endtask

  task automatic test_abort();
    apply_reset();
    do_config(1, 4);
    push_word(rand_word(), 0);
    push_word(rand_word(), 0);
    tick(3);
    do_config(1, 4);
    for (int k = 0; k < 4; k++) push_q.push_back(rand_word());
    build_expected(1, 4);
    for (int k = 0; k < 4; k++) push_word(push_q[k], 0);
    wait_outputs(1, 50);
    tick(3);
    vectors++; if (out_q.size() != 1) begin miscompares++; $display("FAIL abort_count: got %0d want 1", out_q.size()); end
    vectors++; if (out_q.size() > 0 && out_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL abort_sum: got %h want %h", out_q[0], exp_q[0]); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL abort_done: got %0d want 1", done_cnt); end
    do_config(5, 0);
    tick(3);
    vectors++; if (done_cnt != 2) begin miscompares++; $display("FAIL zero_cfg_done: got %0d want 2", done_cnt); end
    vectors++; if (out_q.size() != 1) begin miscompares++; $display("FAIL zero_cfg_out: got %0d want 1", out_q.size()); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.avail_in = 0;
    do_config(2, 3);
    for (int k = 0; k < 5; k++) push_word(rand_word(), 0);
    tick(2);
    bus.avail_in = 1;
    #2 rst = 1'b0;
    #1;
    vectors++; if (bus.data_out !== '0) begin miscompares++; $display("FAIL mid_rst_data: got %h want 0", bus.data_out); end
    vectors++; if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", bus.valid_out); end
    vectors++; if (bus.avail_out !== 1'b1) begin miscompares++; $display("FAIL mid_rst_avail: got %b want 1", bus.avail_out); end
    tick(2);
    clear_books();
    rst = 1'b1;
    tick();
    do_config(1, 1);
    tick(10);
    vectors++; if (out_q.size() != 0) begin miscompares++; $display("FAIL mid_rst_fifo: got %0d outputs want 0", out_q.size()); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int round = 0; round < 5; round++) begin
      int it, rd;
      it = $urandom_range(1, 3);
      rd = $urandom_range(1, 5);
      out_q.delete(); push_q.delete(); done_cnt = 0;
      for (int k = 0; k < it*rd; k++) push_q.push_back(rand_word());
      build_expected(it, rd);
      stop_rand = 0;
      fork
        begin
          while (!stop_rand) begin bus.avail_in = 1'($urandom_range(0, 1)); tick(); end
        end
      join_none
      // First push shares the configure cycle.
      configure = 1; num_iters = 16'(it); num_reads = 16'(rd);
      bus.valid_in = 1; bus.data_in = push_q[0];
      tick();
      configure = 0; bus.valid_in = 0;
      for (int k = 1; k < it*rd; k++) push_word(push_q[k], $urandom_range(0, 2));
      wait_outputs(it, 400);
      stop_rand = 1;
      wait fork;
      bus.avail_in = 1;
      tick(3);
      vectors++; if (out_q.size() != it) begin miscompares++; $display("FAIL rand%0d_count: got %0d want %0d", round, out_q.size(), it); end
      for (int j = 0; j < it && j < out_q.size(); j++) begin
        vectors++; if (out_q[j] !== exp_q[j]) begin miscompares++; $display("FAIL rand%0d_group%0d: got %h want %h", round, j, out_q[j], exp_q[j]); end
      end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL rand%0d_done: got %0d want 1", round, done_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_iter();
    test_stall();
    test_wrap();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
